// File: rtl/dct_pkg.sv
// Shared constants and FSM state type for the DCT matrix-multiply stage.
package dct_pkg;

    localparam int unsigned N_DEF  = 8;
    localparam int unsigned DW_DEF = 32;
    localparam int unsigned IDX_W  = $clog2(N_DEF);
    localparam int unsigned ADDR_W = 2 * IDX_W;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } sched_state_e;

endpackage

// File: rtl/idx_counter.sv
// 2-D wrap counter: inner index increments on en, carries into outer index.
// last is set once all (2**W)*(2**W) pairs have been counted; clr has priority over en.
module idx_counter
    import dct_pkg::*;
#(
    parameter int unsigned W = IDX_W
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] inner,
    output logic [W-1:0] outer,
    output logic         last
);

    logic [2*W:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign inner = cnt_q[W-1:0];
    assign outer = cnt_q[2*W-1:W];
    assign last  = cnt_q[2*W];

endmodule

// File: rtl/dot_pro_sched.sv
// Sequencer for the NxN dot-product engine: issues all (row, col) pairs, collects results.
// DOT_PRO_SCHED_TRANSPOSE_EN stores each result at {col, row} instead of {row, col}.
module dot_pro_sched
    import dct_pkg::*;
#(
    parameter int unsigned N   = N_DEF,
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned TMO = 64
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(N)-1:0]     row_idx,
    output logic [$clog2(N)-1:0]     col_idx,
    output logic                     dp_din_valid,
    input  logic [DW-1:0]            dp_dout,
    input  logic                     dp_dout_valid,
    output logic                     res_we,
    output logic [2*$clog2(N)-1:0]   res_addr,
    output logic [DW-1:0]            res_data
);

    localparam int unsigned IdxW = $clog2(N);
    localparam int unsigned TmoW = $clog2(TMO);

    sched_state_e state_d, state_q;
    logic busy_d, busy_q, done_d, done_q, err_d, err_q, din_valid_d, din_valid_q;
    logic res_we_d, res_we_q;
    logic [2*IdxW-1:0] res_addr_d, res_addr_q;
    logic [DW-1:0] res_data_d, res_data_q;
    logic [TmoW-1:0] tmo_d, tmo_q;

    logic iss_clr, iss_en, iss_last, rcv_clr, rcv_en, rcv_last;
    logic [IdxW-1:0] rcv_inner, rcv_outer;

    idx_counter #(.W(IdxW)) u_issue_cnt (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (iss_clr),
        .en    (iss_en),
        .inner (col_idx),
        .outer (row_idx),
        .last  (iss_last)
    );

    idx_counter #(.W(IdxW)) u_result_cnt (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (rcv_clr),
        .en    (rcv_en),
        .inner (rcv_inner),
        .outer (rcv_outer),
        .last  (rcv_last)
    );

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        din_valid_d = din_valid_q;
        res_we_d    = 1'b0;
        res_addr_d  = res_addr_q;
        res_data_d  = res_data_q;
        tmo_d       = tmo_q;
        iss_clr     = 1'b0;
        iss_en      = 1'b0;
        rcv_clr     = 1'b0;
        rcv_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                iss_clr = 1'b1;
                rcv_clr = 1'b1;
                tmo_d   = '0;
                if (start) begin
                    state_d     = StIssue;
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    din_valid_d = 1'b1;
                end
                if (dp_dout_valid) err_d = 1'b1;
            end
            StIssue: begin
                iss_en = !iss_last;
                if (&{row_idx, col_idx}) begin
                    state_d     = StDrain;
                    din_valid_d = 1'b0;
                end
            end
            StDrain: begin
                if (rcv_last) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (dp_dout_valid) begin
                    tmo_d = '0;
                end else if (tmo_q == TmoW'(TMO - 1)) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (dp_dout_valid) err_d = 1'b1;
            end
        endcase

        // Results are in issue order, so the result counter is the result's (row, col).
        if ((state_q == StIssue || state_q == StDrain) && dp_dout_valid) begin
            if (rcv_last) begin
                err_d = 1'b1;
            end else begin
                rcv_en     = 1'b1;
                res_we_d   = 1'b1;
                res_data_d = dp_dout;
`ifdef DOT_PRO_SCHED_TRANSPOSE_EN
                res_addr_d = {rcv_inner, rcv_outer};
`else
                res_addr_d = {rcv_outer, rcv_inner};
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            din_valid_q <= 1'b0;
            res_we_q    <= 1'b0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            din_valid_q <= din_valid_d;
            res_we_q    <= res_we_d;
            res_addr_q  <= res_addr_d;
            res_data_q  <= res_data_d;
            tmo_q       <= tmo_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign dp_din_valid = din_valid_q;
    assign res_we       = res_we_q;
    assign res_addr     = res_addr_q;
    assign res_data     = res_data_q;

endmodule

// File: tb/tb_dot_pro_sched.sv
// Self-checking bench for dot_pro_sched: 10-cycle engine model with A=I, scoreboard of writes.
module tb_dot_pro_sched;

    localparam int N = 8, NN = 64, TMO = 64, LAT = 10;

    logic        clk = 1'b0, nrst = 1'b0, start = 1'b0, inject = 1'b0;
    logic        busy, done, err, dp_din_valid, dp_dout_valid, res_we;
    logic [2:0]  row_idx, col_idx;
    logic [31:0] dp_dout;
    logic [5:0]  res_addr;
    logic [31:0] res_data;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, drop = 0, iss_idx = 0;
    int wr_total = 0, done_total = 0, done_cyc = 0, last_wr_cyc = 0;
    int din_total = 0, din_run = 0, last_run = 0;
    logic [5:0] addr_of_10 = '0;
    logic [LAT-1:0] pv;
    logic [31:0] pd [LAT];
    logic [37:0] exp_q [$];
    logic keep;

    dot_pro_sched #(.N(N), .DW(32), .TMO(TMO)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .row_idx       (row_idx),
        .col_idx       (col_idx),
        .dp_din_valid  (dp_din_valid),
        .dp_dout       (dp_dout),
        .dp_dout_valid (dp_dout_valid),
        .res_we        (res_we),
        .res_addr      (res_addr),
        .res_data      (res_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // IEEE-754 single encoding of a small non-negative integer.
    function automatic logic [31:0] fp32(input int v);
        int e;
        logic [31:0] sh;
        e = 0;
        if (v == 0) return 32'h0;
        for (int i = 0; i < 31; i++) if ((v >> i) != 0) e = i;
        sh = 32'(v) << (23 - e);
        return {1'b0, 8'(127 + e), sh[22:0]};
    endfunction

    function automatic logic [5:0] exp_addr(input int r, input int c);
`ifdef DOT_PRO_SCHED_TRANSPOSE_EN
        return 6'(c * N + r);
`else
        return 6'(r * N + c);
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    assign keep = dp_din_valid && (iss_idx < NN - drop);
    assign dp_dout_valid = pv[LAT-1] | inject;
    assign dp_dout = inject ? 32'hDEAD_BEEF : pd[LAT-1];

    // Engine model (A = I, so result (r,c) = B[r][c] = r*8+c) and scoreboard producer.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pv <= '0;
            for (int i = 0; i < LAT; i++) pd[i] <= '0;
            iss_idx <= 0;
            exp_q.delete();
        end else begin
            pv    <= {pv[LAT-2:0], keep};
            pd[0] <= fp32(int'(row_idx) * N + int'(col_idx));
            for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
            if (dp_din_valid) begin
                chk("issue_order", 64'({row_idx, col_idx}), 64'(iss_idx[5:0]));
                iss_idx <= iss_idx + 1;
                if (keep)
                    exp_q.push_back({exp_addr(int'(row_idx), int'(col_idx)),
                                     fp32(int'(row_idx) * N + int'(col_idx))});
            end else begin
                iss_idx <= 0;
            end
        end
    end

    always @(posedge clk) begin
        if (dp_din_valid) begin
            din_total <= din_total + 1;
            din_run   <= din_run + 1;
        end else begin
            if (din_run != 0) last_run <= din_run;
            din_run <= 0;
        end
    end

    // Scoreboard consumer and done monitor.
    always @(negedge clk) begin
        logic [37:0] e;
        if (res_we) begin
            wr_total    <= wr_total + 1;
            last_wr_cyc <= cyc;
            if (res_data == fp32(10)) addr_of_10 <= res_addr;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(res_addr), 64'h3f_ffff_ffff);
            end else begin
                e = exp_q.pop_front();
                chk("res_addr", 64'(res_addr), 64'(e[37:32]));
                chk("res_data", 64'(res_data), 64'(e[31:0]));
            end
        end
        if (done) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc;
            chk("busy_in_done", 64'(busy), 64'(0));
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_row"}, 64'(row_idx), 64'(0));
        chk({tag, "_col"}, 64'(col_idx), 64'(0));
        chk({tag, "_din_valid"}, 64'(dp_din_valid), 64'(0));
        chk({tag, "_res_we"}, 64'(res_we), 64'(0));
        chk({tag, "_res_addr"}, 64'(res_addr), 64'(0));
        chk({tag, "_res_data"}, 64'(res_data), 64'(0));
    endtask

    // One full product; exp_lat > 0 is start-to-done latency, else done must follow
    // the last write by TMO cycles.
    task automatic run(input string tag, input int extra_at, input int drp, input int exp_wr,
                       input bit exp_err, input int exp_lat);
        int t0, wr0, dn0, din0;
        drop = drp;
        wr0  = wr_total;
        dn0  = done_total;
        din0 = din_total;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        t0 = cyc;
        chk({tag, "_err_cleared"}, 64'(err), 64'(0));
        chk({tag, "_busy_set"}, 64'(busy), 64'(1));
        for (int k = 1; k < 400 && done_total == dn0; k++) begin
            @(negedge clk);
            start = (k == extra_at);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk({tag, "_writes"}, 64'(wr_total - wr0), 64'(exp_wr));
        chk({tag, "_done_pulses"}, 64'(done_total - dn0), 64'(1));
        if (exp_lat > 0) chk({tag, "_done_latency"}, 64'(done_cyc - t0), 64'(exp_lat));
        else chk({tag, "_timeout_gap"}, 64'(done_cyc - last_wr_cyc), 64'(TMO));
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        chk({tag, "_busy_after"}, 64'(busy), 64'(0));
        chk({tag, "_din_count"}, 64'(din_total - din0), 64'(NN));
        chk({tag, "_din_run"}, 64'(last_run), 64'(NN));
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    typedef struct {
        string tag;
        int    extra_at;
        int    drop;
        int    exp_wr;
        bit    exp_err;
        int    exp_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"basic",      -1, 0, 64, 1'b0, LAT + NN + 1};
        vecs[1] = '{"start_busy", 20, 0, 64, 1'b0, LAT + NN + 1};
        vecs[2] = '{"timeout",    -1, 3, 61, 1'b1, 0};
        vecs[3] = '{"after_tmo",  -1, 0, 64, 1'b0, LAT + NN + 1};

        #12;
        chk_reset_vals("por");
        @(negedge clk) nrst = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i])
            run(vecs[i].tag, vecs[i].extra_at, vecs[i].drop, vecs[i].exp_wr,
                vecs[i].exp_err, vecs[i].exp_lat);

`ifdef DOT_PRO_SCHED_TRANSPOSE_EN
        chk("addr_of_rc_1_2", 64'(addr_of_10), 64'(17));
`else
        chk("addr_of_rc_1_2", 64'(addr_of_10), 64'(10));
`endif

        // Result with nothing outstanding while idle.
        begin
            int wr0;
            wr0 = wr_total;
            @(negedge clk) inject = 1'b1;
            @(negedge clk) inject = 1'b0;
            repeat (3) @(negedge clk);
            chk("idle_result_err", 64'(err), 64'(1));
            chk("idle_result_nowrite", 64'(wr_total - wr0), 64'(0));
        end

        // Asynchronous reset 30 cycles into ISSUE.
        begin
            int t0;
            drop = 0;
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            t0 = cyc;
            for (int k = 0; k < 100 && cyc - t0 < 30; k++) @(negedge clk);
            chk("pre_rst_din_valid", 64'(dp_din_valid), 64'(1));
            #2 nrst = 1'b0;
            #1 chk_reset_vals("mid_rst");
            repeat (2) @(negedge clk);
            nrst = 1'b1;
            repeat (2) @(negedge clk);
            run("post_rst", -1, 0, 64, 1'b0, LAT + NN + 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dot_pro_sched.md
Name: dot_pro_sched

Overview:
- Sequencer for the 8x8 floating-point dot-product engine used in the DCT matrix-multiply stage.
- On `start`, issues all N*N (row, column) index pairs to the engine, one per cycle, and collects the N*N results in order.
- Writes each result to the result buffer and signals completion.
- Sits between the DCT top-level control and the dot-product engine plus its row/column operand muxes.

Parameters:
- N, 8, matrix dimension (power of 2, 2..16)
- DW, 32, result data width (IEEE-754 single)
- TMO, 64, max cycles waiting for outstanding results in DRAIN before the error flag is raised

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  begin one N*N product; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the last result is written
- err  out  1  sticky; set on timeout or on an unexpected engine result; cleared only by reset or an accepted start
- row_idx  out  log2(N)  row operand select to the operand mux
- col_idx  out  log2(N)  column operand select to the operand mux
- dp_din_valid  out  1  engine input valid; operands selected by row_idx/col_idx this cycle
- dp_dout  in  DW  engine result
- dp_dout_valid  in  1  engine result valid
- res_we  out  1  result buffer write enable
- res_addr  out  2*log2(N)  result buffer address
- res_data  out  DW  result buffer write data

Behaviour:
- Reset values: busy=0, done=0, err=0, row_idx=0, col_idx=0, dp_din_valid=0, res_we=0, res_addr=0, res_data=0. State = IDLE, all counters 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 goes to ISSUE.
  - Clears err, issue counter, result counter and timeout counter.
- ISSUE:
  - dp_din_valid=1 every cycle; row_idx/col_idx registered, col_idx inner (increments each cycle), row_idx outer.
  - Issue order: (0,0),(0,1)..(0,N-1),(1,0)..(N-1,N-1). Exactly N*N issues, no gaps.
  - After issuing (N-1,N-1) goes to DRAIN; row_idx/col_idx wrap to 0.
- DRAIN: dp_din_valid=0; waits for the result counter to reach N*N.
- Results (ISSUE or DRAIN):
  - Each dp_dout_valid registers res_data=dp_dout, res_we=1 and res_addr=result counter, one cycle after dp_dout_valid.
  - The result counter then increments.
  - Results are assumed in issue order; the engine is in-order and fully pipelined with no backpressure.
- Overlap: results may start returning while still in ISSUE; the block must accept one result per cycle concurrently with issue.
- Completion:
  - When the N*N-th result is written, go to DONE.
  - DONE: done=1 for one cycle, busy=0 in that same cycle, then IDLE.
- busy is 1 in ISSUE and DRAIN only.
- Timeout: in DRAIN a counter runs, reset on every dp_dout_valid. On reaching TMO, set err and go to DONE (done still pulses).
- Unexpected result: dp_dout_valid in IDLE or DONE sets err; no write occurs.
- Ignored start: start while busy or in DONE is ignored.
- Asynchronous reset mid-operation: aborts immediately to the reset values. Results still in flight in the engine afterwards set err only if they arrive after reset release in IDLE. Top level must reset the engine with the same nrst.
- Width rules:
  - Issue and result counters are 2*log2(N)+1 bits so N*N is representable.
  - res_addr is the low 2*log2(N) bits.

Optional Feature:
- Macro: DOT_PRO_SCHED_TRANSPOSE_EN
- Defined: res_addr = {col, row} of the result, i.e. the result is stored transposed (the result index with its two log2(N) fields swapped). The second DCT pass can then reuse the same row-major operand path.
- Undefined: res_addr = {row, col}, row-major.
- All other behaviour is identical.

Decomposition:
- Shared package dct_pkg:
  - N and DW defaults.
  - IDX_W = log2(N) and ADDR_W = 2*IDX_W.
  - Enumerated state type for IDLE/ISSUE/DRAIN/DONE.
- Sub-module idx_counter (2-D wrap counter: inner/outer index with enable, clear and last flag), instantiated twice: once for issue, once for results.

Test Plan:
- Basic run, engine model with 10-cycle latency, A=I, B with B[i][j]=i*8+j:
  - 64 writes, res_addr 0..63 in order, res_data = B values.
  - done pulse exactly 10+64+1 cycles after start was sampled; busy low in the done cycle.
- Issue sequence: check dp_din_valid high exactly 64 consecutive cycles; row_idx/col_idx sequence (0,0)..(7,7) with no gaps or repeats.
- Start while busy: pulse start at cycle 20 of a run -> ignored; still exactly 64 writes and one done pulse.
- Timeout: engine drops the last 3 results -> err=1 and done pulse TMO cycles after the 61st result; err cleared by the next start.
- Reset mid-ISSUE at cycle 30 -> all outputs at reset values asynchronously. A fresh run after release completes with 64 writes and err=0 (engine reset too).
- With DOT_PRO_SCHED_TRANSPOSE_EN: result k=(r,c)=(1,2) is written to res_addr=17; without the macro, to res_addr=10.
